// File: rtl/usb_tx_pkg.sv
// Shared types and line-state constants for the USB transmit line encoder.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    EOP_SE0 = 2'd2,
    EOP_J   = 2'd3
  } usb_tx_state_t;

  // Line states encoded as {d_plus, d_minus}.
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam logic [1:0] EOP_SE0_BITS = 2'd2;

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// Per-bit NRZI line state and consecutive-ones tracking; flags when the next bit must be a stuffed 0.
module usb_nrzi_stuffer
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_bit_valid,
  input  logic       i_bit_in,
  input  logic       i_clear,
  output logic [1:0] o_line,
  output logic       o_stuff_now
);

  logic       r_nrzi_j;
  logic [2:0] r_ones;
  logic       w_base_j;
  logic [2:0] w_base_ones;

  // Clear acts before a coincident bit, so a packet's first bit is encoded from J.
  always_comb begin
    w_base_j    = i_clear ? 1'b1 : r_nrzi_j;
    w_base_ones = i_clear ? 3'd0 : r_ones;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_nrzi_j <= 1'b1;
      r_ones   <= 3'd0;
    end else if (i_bit_valid) begin
      if (i_bit_in) begin
        r_nrzi_j <= w_base_j;
        r_ones   <= w_base_ones + 3'd1;
      end else begin
        r_nrzi_j <= ~w_base_j;
        r_ones   <= 3'd0;
      end
    end else begin
      r_nrzi_j <= w_base_j;
      r_ones   <= w_base_ones;
    end
  end

  assign o_line      = r_nrzi_j ? LINE_J : LINE_K;
  assign o_stuff_now = (r_ones == STUFF_LIMIT);

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB full-speed TX line encoder: one-byte holding register, LSB-first serialiser, bit stuffing, NRZI, EOP.
// Sticky overrun detection is built only when USB_TX_OVERRUN_DET_EN is defined.
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  input  logic       eop_req,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_overrun
);

  localparam logic [7:0] BIT_RELOAD = 8'(CLKS_PER_BIT - 1);

  usb_tx_state_t r_state;
  usb_tx_state_t w_next_state;

  logic [7:0] r_hold_dat;
  logic       r_hold_full;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic [7:0] r_timer;
  logic [1:0] r_eop_cnt;
  logic       r_eop_q;
  logic       r_eop_pending;

  logic       w_tick;
  logic       w_last_bit;
  logic       w_eop_edge;
  logic [2:0] w_idx_nx;
  logic       w_stuff_now;
  logic [1:0] w_nrzi_line;
  logic       w_start_byte;
  logic       w_next_bit;
  logic       w_stuff_bit;
  logic       w_enter_eop;
  logic       w_bit_valid;
  logic       w_bit_in;
  logic       w_stuff_clr;

  assign w_tick     = (r_timer == 8'd0);
  assign w_last_bit = (r_bit_idx == 3'd7);
  assign w_eop_edge = eop_req & ~r_eop_q;
  assign w_idx_nx   = r_bit_idx + 3'd1;
  assign tx_ready   = ~r_hold_full;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_next_state = SEND;
        end else if (r_eop_pending) begin
          w_next_state = EOP_SE0;
        end
      end
      SEND: begin
        // A byte ends only once bit 7 and any stuff bit owed after it are out.
        if (w_tick && !w_stuff_now && w_last_bit) begin
          if (r_hold_full) begin
            w_next_state = SEND;
          end else if (r_eop_pending) begin
            w_next_state = EOP_SE0;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      EOP_SE0: begin
        if (w_tick && (r_eop_cnt == (EOP_SE0_BITS - 2'd1))) begin
          w_next_state = EOP_J;
        end
      end
      EOP_J: begin
        if (w_tick) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_start_byte       = 1'b0;
    w_next_bit         = 1'b0;
    w_stuff_bit        = 1'b0;
    w_stuff_clr        = 1'b1;
    tx_busy            = 1'b0;
    {d_plus, d_minus}  = LINE_J;
    case (r_state)
      IDLE: begin
        w_start_byte = r_hold_full;
      end
      SEND: begin
        tx_busy           = 1'b1;
        w_stuff_clr       = 1'b0;
        {d_plus, d_minus} = w_nrzi_line;
        if (w_tick) begin
          if (w_stuff_now) begin
            w_stuff_bit = 1'b1;
          end else if (!w_last_bit) begin
            w_next_bit = 1'b1;
          end else begin
            w_start_byte = r_hold_full;
          end
        end
      end
      EOP_SE0: begin
        tx_busy           = 1'b1;
        {d_plus, d_minus} = LINE_SE0;
      end
      EOP_J: begin
        tx_busy           = 1'b1;
        {d_plus, d_minus} = LINE_J;
      end
      default: begin
        tx_busy           = 1'b0;
        {d_plus, d_minus} = LINE_J;
      end
    endcase
  end

  assign w_enter_eop = (w_next_state == EOP_SE0) && (r_state != EOP_SE0);
  assign w_bit_valid = w_start_byte | w_next_bit | w_stuff_bit;
  // Stuff periods present a 0, which both toggles the line and clears the ones count.
  assign w_bit_in    = w_start_byte ? r_hold_dat[0] : (w_next_bit & r_shift[w_idx_nx]);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_hold_dat    <= 8'd0;
      r_hold_full   <= 1'b0;
      r_shift       <= 8'd0;
      r_bit_idx     <= 3'd0;
      r_timer       <= 8'd0;
      r_eop_cnt     <= 2'd0;
      r_eop_q       <= 1'b1;
      r_eop_pending <= 1'b0;
    end else begin
      r_eop_q <= eop_req;

      if (w_eop_edge) begin
        r_eop_pending <= 1'b1;
      end else if (w_enter_eop) begin
        r_eop_pending <= 1'b0;
      end

      if (tx_load && !r_hold_full) begin
        r_hold_dat <= tx_byte;
      end
      if (w_start_byte) begin
        r_hold_full <= 1'b0;
      end else if (tx_load) begin
        r_hold_full <= 1'b1;
      end

      if (w_start_byte) begin
        r_shift   <= r_hold_dat;
        r_bit_idx <= 3'd0;
      end else if (w_next_bit) begin
        r_bit_idx <= w_idx_nx;
      end

      if (w_start_byte || w_enter_eop) begin
        r_timer <= BIT_RELOAD;
      end else if (r_state != IDLE) begin
        r_timer <= w_tick ? BIT_RELOAD : (r_timer - 8'd1);
      end

      if (w_enter_eop) begin
        r_eop_cnt <= 2'd0;
      end else if ((r_state == EOP_SE0) && w_tick) begin
        r_eop_cnt <= r_eop_cnt + 2'd1;
      end
    end
  end

`ifdef USB_TX_OVERRUN_DET_EN
  logic r_overrun;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_overrun <= 1'b0;
    end else if (tx_load && r_hold_full) begin
      r_overrun <= 1'b1;
    end else if (w_eop_edge) begin
      r_overrun <= 1'b0;
    end
  end

  assign tx_overrun = r_overrun;
`else
  assign tx_overrun = 1'b0;
`endif

  usb_nrzi_stuffer u_nrzi_stuffer (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_bit_valid (w_bit_valid),
    .i_bit_in    (w_bit_in),
    .i_clear     (w_stuff_clr),
    .o_line      (w_nrzi_line),
    .o_stuff_now (w_stuff_now)
  );

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Bench for usb_tx_line_encoder: per-clock line waveforms against hand tables and a bit-level packet model.
`timescale 1ns/1ps
module tb_usb_tx_line_encoder;

  localparam int CLKS = 8;
  localparam int TAIL = 4;
  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;
`ifdef USB_TX_OVERRUN_DET_EN
  localparam logic [7:0] OVR_EXP = 8'd1;
`else
  localparam logic [7:0] OVR_EXP = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] tx_byte = 8'd0;
  logic       tx_load = 1'b0;
  logic       eop_req = 1'b1;
  logic       tx_ready, tx_busy, d_plus, d_minus, tx_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] exp_q[$];
  logic [2:0] act_q[$];
  logic [7:0] pkt_q[$];

  typedef struct {
    logic [7:0]  dat;
    int          nper;
    logic [15:0] dp;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  usb_tx_line_encoder #(.CLKS_PER_BIT(CLKS)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_byte    (tx_byte),
    .tx_load    (tx_load),
    .eop_req    (eop_req),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .d_plus     (d_plus),
    .d_minus    (d_minus),
    .tx_overrun (tx_overrun)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_per(input logic [1:0] line, input logic busy);
    repeat (CLKS) exp_q.push_back({busy, line});
  endtask

  task automatic push_tail();
    repeat (TAIL) exp_q.push_back({1'b0, LJ});
  endtask

  // Reference: walk the bits LSB-first, insert a 0 after six ones, NRZI from J.
  task automatic model_build(input bit eop);
    int ones;
    bit j;
    logic [7:0] b;
    ones = 0;
    j = 1'b1;
    exp_q.delete();
    foreach (pkt_q[n]) begin
      b = pkt_q[n];
      for (int i = 0; i < 8; i++) begin
        if (b[i]) ones++;
        else begin ones = 0; j = !j; end
        push_per(j ? LJ : LK, 1'b1);
        if (ones == 6) begin
          ones = 0;
          j = !j;
          push_per(j ? LJ : LK, 1'b1);
        end
      end
    end
    if (eop) begin
      push_per(LSE0, 1'b1);
      push_per(LSE0, 1'b1);
      push_per(LJ, 1'b1);
    end
    push_tail();
  endtask

  task automatic capture(input int n);
    act_q.delete();
    repeat (n) begin
      @(negedge clk);
      act_q.push_back({tx_busy, d_plus, d_minus});
    end
  endtask

  task automatic cmp_wave(input string name);
    int bad;
    bad = -1;
    n_tests++;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (bad < 0 && (k >= act_q.size() || act_q[k] !== exp_q[k])) bad = k;
    end
    if (bad >= 0) begin
      n_fail++;
      if (bad < act_q.size())
        $display("FAIL %s: cycle %0d busy/dp/dm got %b expected %b", name, bad, act_q[bad], exp_q[bad]);
      else
        $display("FAIL %s: captured %0d cycles expected %0d", name, act_q.size(), exp_q.size());
    end
  endtask

  task automatic run_packet(input string name, input bit eop, input int dly);
    @(negedge clk);
    tx_byte = pkt_q[0];
    tx_load = 1'b1;
    if (eop && dly == 0 && pkt_q.size() == 1) eop_req = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    chk({name, "_ready_low"}, tx_ready, 8'd0);
    fork
      capture(exp_q.size());
      begin
        for (int n = 1; n < pkt_q.size(); n++) begin
          int t;
          t = 0;
          do begin @(negedge clk); t++; end while (!tx_ready && t < 20 * CLKS);
          chk({name, "_ready_wait"}, tx_ready, 8'd1);
          tx_byte = pkt_q[n];
          tx_load = 1'b1;
          if (eop && dly == 0 && n == pkt_q.size() - 1) eop_req = 1'b1;
          @(negedge clk);
          tx_load = 1'b0;
        end
        if (eop && !eop_req) begin
          repeat (dly) @(negedge clk);
          eop_req = 1'b1;
        end
      end
    join
    cmp_wave(name);
    eop_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_eop_only(input string name);
    exp_q.delete();
    push_per(LSE0, 1'b1);
    push_per(LSE0, 1'b1);
    push_per(LJ, 1'b1);
    push_tail();
    @(negedge clk);
    eop_req = 1'b1;
    @(negedge clk);
    capture(exp_q.size());
    cmp_wave(name);
    eop_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h80, 8, 16'h002A};
    vecs[1] = '{8'hFF, 9, 16'h003F};
    vecs[2] = '{8'h00, 8, 16'h00AA};
    vecs[3] = '{8'h01, 8, 16'h0055};
    vecs[4] = '{8'h7E, 9, 16'h0080};
    vecs[5] = '{8'h3F, 9, 16'h00BF};

    repeat (3) @(negedge clk);
    chk("rst_dplus", d_plus, 8'd1);
    chk("rst_dminus", d_minus, 8'd0);
    chk("rst_ready", tx_ready, 8'd1);
    chk("rst_busy", tx_busy, 8'd0);
    chk("rst_overrun", tx_overrun, 8'd0);

    // eop_req already high at release must not start an EOP
    n_rst = 1'b1;
    exp_q.delete();
    repeat (5 * CLKS) exp_q.push_back({1'b0, LJ});
    capture(exp_q.size());
    cmp_wave("eop_high_at_release");
    eop_req = 1'b0;
    @(negedge clk);
    run_eop_only("eop_no_data");

    for (int v = 0; v < 6; v++) begin
      exp_q.delete();
      for (int i = 0; i < vecs[v].nper; i++) push_per(vecs[v].dp[i] ? LJ : LK, 1'b1);
      push_tail();
      pkt_q.delete();
      pkt_q.push_back(vecs[v].dat);
      run_packet($sformatf("vec_%02h", vecs[v].dat), 1'b0, 0);
    end

    pkt_q.delete();
    pkt_q.push_back(8'hF0);
    pkt_q.push_back(8'h0F);
    model_build(1'b1);
    run_packet("f0_0f_eop", 1'b1, 10 * CLKS);

    // second load accepted into the holding register, third dropped while full
    pkt_q.delete();
    pkt_q.push_back(8'h80);
    pkt_q.push_back(8'h55);
    model_build(1'b0);
    @(negedge clk);
    tx_byte = 8'h80;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    fork
      capture(exp_q.size());
      begin
        @(negedge clk);
        chk("ovr_ready_hi", tx_ready, 8'd1);
        tx_byte = 8'h55;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        @(negedge clk);
        chk("ovr_ready_lo", tx_ready, 8'd0);
        tx_byte = 8'hFF;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
      end
    join
    cmp_wave("ovr_drop");
    chk("ovr_flag", tx_overrun, OVR_EXP);
    run_eop_only("ovr_eop");
    chk("ovr_cleared", tx_overrun, 8'd0);

    pkt_q.delete();
    pkt_q.push_back(8'hA5);
    model_build(1'b0);
    while (exp_q.size() > 3 * CLKS + CLKS / 2) void'(exp_q.pop_back());
    @(negedge clk);
    tx_byte = 8'hA5;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    capture(exp_q.size());
    cmp_wave("a5_partial");
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_dplus", d_plus, 8'd1);
    chk("midrst_dminus", d_minus, 8'd0);
    chk("midrst_busy", tx_busy, 8'd0);
    chk("midrst_ready", tx_ready, 8'd1);
    @(negedge clk);
    n_rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < vecs[0].nper; i++) push_per(vecs[0].dp[i] ? LJ : LK, 1'b1);
    push_tail();
    pkt_q.delete();
    pkt_q.push_back(8'h80);
    run_packet("sync_after_rst", 1'b0, 0);

    for (int r = 0; r < 15; r++) begin
      int nb;
      bit eop;
      int dly;
      logic [7:0] b;
      nb = $urandom_range(1, 3);
      pkt_q.delete();
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 1) == 1) b = b | 8'hFC;
        pkt_q.push_back(b);
      end
      eop = ($urandom_range(0, 1) == 1);
      dly = $urandom_range(0, 3 * CLKS);
      model_build(eop);
      run_packet($sformatf("rand%0d", r), eop, dly);
      chk($sformatf("rand%0d_no_ovr", r), tx_overrun, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
